// File: rtl/multicycle_datapath_if.sv
// multicycle_datapath_if
//   Instruction and data memory buses of the multi-cycle datapath. Both sides
//   use a level req / single-cycle ack handshake; a request stays asserted with
//   stable address/data until the cycle in which ack is seen.
//   imem: imem_req, imem_addr (core -> mem), imem_ack, imem_rdata (mem -> core)
//   dmem: dmem_req, dmem_we, dmem_addr, dmem_wdata (core -> mem),
//         dmem_ack, dmem_rdata (mem -> core)
//   Modports: master = core side, slave = memory / peripheral side.
interface multicycle_datapath_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            dmem_req;
  logic [1:0]      dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/multicycle_datapath.sv
// multicycle_datapath
//   Multi-cycle RV32-style datapath sequenced FETCH -> DECODE -> EXEC ->
//   [MEM] -> WB. Decoded control comes from an external controller; memories
//   sit behind the req/ack buses in multicycle_datapath_if.
//   Ports: clk, reset (async, active high); controller inputs PCSrc, RegWrite,
//   ResultSrc, RF_WD_SRC, MemWrite, ALUSrc, ImmSrc, ALUControl;
//   Debug_Source_select / Debug_out debug register read; bus (master modport);
//   Zero, PC, Instr, RF_OUT1, RF_OUT2, retire, bus_err status outputs.
//   Optional: define MULTICYCLE_DATAPATH_BUS_TIMEOUT_EN to bound bus waits to
//   TIMEOUT_CYCLES; a timeout sets sticky bus_err and parks the FSM in HALT.
//
//   state    | meaning
//   S_FETCH  | imem request pending, Instr loaded on ack
//   S_DECODE | register operands and immediate latched
//   S_EXEC   | ALU result and Zero latched
//   S_MEM    | dmem request pending, MDR loaded on ack
//   S_WB     | register write, PC update, retire pulse
//   S_HALT   | bus timeout, frozen until reset (optional)
module multicycle_datapath #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter int              TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 PCSrc,
  input  logic                 RegWrite,
  input  logic                 ResultSrc,
  input  logic                 RF_WD_SRC,
  input  logic [1:0]           MemWrite,
  input  logic [1:0]           ALUSrc,
  input  logic [2:0]           ImmSrc,
  input  logic [3:0]           ALUControl,
  input  logic [4:0]           Debug_Source_select,
  multicycle_datapath_if.master bus,
  output logic                 Zero,
  output logic [XLEN-1:0]      PC,
  output logic [31:0]          Instr,
  output logic [XLEN-1:0]      RF_OUT1,
  output logic [XLEN-1:0]      RF_OUT2,
  output logic [XLEN-1:0]      Debug_out,
  output logic                 retire,
  output logic                 bus_err
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
`ifdef MULTICYCLE_DATAPATH_BUS_TIMEOUT_EN
    , S_HALT
`endif
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] a_q, b_q, imm_q, alu_q, mdr_q;
  logic [1:0]      we_q;
  logic [XLEN-1:0] rf [32];
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm, src_a, src_b, alu_y, result, pc_plus4, wd;
  logic [4:0]      rs1, rs2, rd;
  logic            rf_we;
  logic            unused_opcode;

`ifdef MULTICYCLE_DATAPATH_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic          wait_tc;
  assign wait_tc = (wait_cnt == '0);
`endif

  assign rs1 = Instr[19:15];
  assign rs2 = Instr[24:20];
  assign rd  = Instr[11:7];
  // opcode bits are decoded by the external controller only
  assign unused_opcode = ^Instr[6:0];

  // Extender: 0 I, 1 S, 2 B, 3 U, 4 J
  always_comb begin
    imm32 = {{20{Instr[31]}}, Instr[31:20]};
    case (ImmSrc)
      3'd1: imm32 = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      3'd2: imm32 = {{20{Instr[31]}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      3'd3: imm32 = {Instr[31:12], 12'b0};
      3'd4: imm32 = {{12{Instr[31]}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
      default: ;
    endcase
  end
  assign imm = XLEN'($signed(imm32));

  assign src_a = ALUSrc[0] ? PC : a_q;
  assign src_b = ALUSrc[1] ? imm_q : b_q;

  always_comb begin
    case (ALUControl)
      4'h1:    alu_y = src_a - src_b;
      4'h2:    alu_y = src_a & src_b;
      4'h3:    alu_y = src_a | src_b;
      4'h4:    alu_y = src_a ^ src_b;
      4'h5:    alu_y = src_a << src_b[SHW-1:0];
      4'h6:    alu_y = src_a >> src_b[SHW-1:0];
      4'h7:    alu_y = XLEN'($signed(src_a) >>> src_b[SHW-1:0]);
      4'h8:    alu_y = XLEN'($signed(src_a) < $signed(src_b));
      4'h9:    alu_y = XLEN'(src_a < src_b);
      default: alu_y = src_a + src_b;
    endcase
  end

  assign result   = ResultSrc ? mdr_q : alu_q;
  assign pc_plus4 = PC + XLEN'(4);
  assign wd       = RF_WD_SRC ? pc_plus4 : result;
  assign rf_we    = (state == S_WB) && RegWrite && (rd != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH: begin
        if (bus.imem_ack) state_n = S_DECODE;
`ifdef MULTICYCLE_DATAPATH_BUS_TIMEOUT_EN
        else if (wait_tc) state_n = S_HALT;
`endif
      end
      S_DECODE: state_n = S_EXEC;
      S_EXEC:   state_n = (MemWrite != 2'b00 || ResultSrc) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.dmem_ack) state_n = S_WB;
`ifdef MULTICYCLE_DATAPATH_BUS_TIMEOUT_EN
        else if (wait_tc) state_n = S_HALT;
`endif
      end
      S_WB:     state_n = S_FETCH;
`ifdef MULTICYCLE_DATAPATH_BUS_TIMEOUT_EN
      S_HALT:   state_n = S_HALT;
`endif
      default:  state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC    <= RESET_PC;
      Instr <= 32'h0000_0013;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      we_q  <= 2'b00;
      Zero  <= 1'b0;
    end else begin
      case (state)
        S_FETCH:  if (bus.imem_ack) Instr <= bus.imem_rdata;
        S_DECODE: begin
          a_q   <= rf[rs1];
          b_q   <= rf[rs2];
          imm_q <= imm;
        end
        S_EXEC: begin
          alu_q <= alu_y;
          Zero  <= (alu_y == '0);
          we_q  <= MemWrite;
        end
        S_MEM:    if (bus.dmem_ack) mdr_q <= bus.dmem_rdata;
        S_WB:     PC <= PCSrc ? result : pc_plus4;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rf_we) begin
      rf[rd] <= wd;
    end
  end

  assign RF_OUT1   = rf[rs1];
  assign RF_OUT2   = rf[rs2];
  assign Debug_out = rf[Debug_Source_select];

  // state sits in S_FETCH during reset, so the fetch request needs explicit gating
  assign bus.imem_req   = (state == S_FETCH) && !reset;
  assign bus.imem_addr  = PC;
  assign bus.dmem_req   = (state == S_MEM);
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = alu_q;
  assign bus.dmem_wdata = b_q;
  assign retire         = (state == S_WB);

`ifdef MULTICYCLE_DATAPATH_BUS_TIMEOUT_EN
  // down-counter reloaded on every entry into a waiting state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= TW'(TIMEOUT_CYCLES - 1);
      bus_err  <= 1'b0;
    end else begin
      if ((state_n == S_FETCH || state_n == S_MEM) && state_n != state)
        wait_cnt <= TW'(TIMEOUT_CYCLES - 1);
      else if (!wait_tc)
        wait_cnt <= wait_cnt - TW'(1);
      if (state_n == S_HALT && state != S_HALT)
        bus_err <= 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign bus_err = 1'b0;
`endif
endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multi-cycle successor to the team's single-cycle RV32 datapath.
- Decoded control comes from the external controller; the block sequences each instruction through an internal FSM (FETCH, DECODE, EXEC, MEM, WB).
- Instruction and data memories are external, behind req/ack handshakes, so wait-stated memories and the UART peripheral bus can stall the core.
- Reuses the team's ALU, Extender and Register_file blocks, widened to XLEN.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, bus wait limit; used only with the optional feature.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- PCSrc, RegWrite, ResultSrc, RF_WD_SRC  in  1 each  controller signals, same meaning as the single-cycle core.
- MemWrite  in  2  store size; 0 = no store.
- ALUSrc  in  2  bit0 selects PC for SrcA; bit1 selects ImmExt for SrcB.
- ImmSrc  in  3  extender format.
- ALUControl  in  4  ALU operation.
- Debug_Source_select  in  5  register-file debug read index.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  XLEN  fetch address (= PC).
- imem_ack  in  1  fetch complete.
- imem_rdata  in  32  fetched instruction.
- dmem_req  out  1  data access request.
- dmem_we  out  2  = latched MemWrite; 0 means read.
- dmem_addr  out  XLEN  = ALUOut.
- dmem_wdata  out  XLEN  = latched rs2.
- dmem_ack  in  1  access complete.
- dmem_rdata  in  XLEN  load data, already size/sign adjusted by memory.
- Zero  out  1  latched ALU zero flag.
- PC, Instr  out  XLEN, 32  current PC and instruction register.
- RF_OUT1, RF_OUT2, Debug_out  out  XLEN  register-file reads.
- retire  out  1  one-cycle pulse in WB.
- bus_err  out  1  sticky timeout flag (optional feature).

Behaviour:
- Reset (async, any state, mid-transfer included):
  - PC = RESET_PC; Instr = 32'h0000_0013 (NOP).
  - Internal A, B, ImmExt, ALUOut and MDR = 0; Zero = 0.
  - State = FETCH; imem_req, dmem_req, retire and bus_err = 0 while reset is high.
  - Register file is cleared.
  - An in-flight ack arriving during reset is ignored.
- FETCH:
  - imem_req = 1, imem_addr = PC.
  - On the edge where imem_ack = 1: Instr <= imem_rdata, go to DECODE.
  - Otherwise stay in FETCH; req and addr stay stable.
- DECODE (1 cycle): latch A <= rs1 read, B <= rs2 read, ImmExt <= Extender(Instr, ImmSrc).
- EXEC (1 cycle):
  - SrcA = ALUSrc[0] ? PC : A; SrcB = ALUSrc[1] ? ImmExt : B.
  - Latch ALUOut and Zero.
  - Next state is MEM if MemWrite != 0 or ResultSrc = 1; otherwise WB.
- MEM:
  - dmem_req = 1; dmem_addr, dmem_we and dmem_wdata are held stable until dmem_ack.
  - On ack: MDR <= dmem_rdata, go to WB.
- WB (1 cycle):
  - Result = ResultSrc ? MDR : ALUOut.
  - Register write data = RF_WD_SRC ? PC+4 : Result.
  - Register write only when RegWrite = 1 and rd != 0; the write enable is never asserted outside WB.
  - PC <= PCSrc ? Result : PC+4, computed modulo 2^XLEN (wraps).
  - retire = 1 for this cycle only; then go to FETCH.
- Control inputs are sampled only in the state that uses them; the controller decodes from Instr, which is stable from DECODE through WB.
- Latency with ack in the same cycle as req: ALU/branch/jump = 4 cycles; load/store = 5 cycles; each wait cycle adds 1.
- imem_req and dmem_req are never high in the same cycle.
- Zero is held from EXEC until the next EXEC.

Optional Feature:
- Macro: MULTICYCLE_DATAPATH_BUS_TIMEOUT_EN.
- Defined:
  - A wait counter is cleared on entry to FETCH or MEM.
  - If ack is still absent after TIMEOUT_CYCLES cycles of req, req drops, bus_err <= 1 (sticky) and the FSM enters HALT.
  - HALT: no requests, no retire, PC and registers frozen; exit only via reset.
- Not defined: no counter, no HALT state, bus_err tied to 0, wait is unbounded.

Test Plan:
- Reset, then release with RESET_PC = 0 and immediate acks -> imem_addr = 0 in the first cycle; retire on cycle 4; PC = 4.
- addi x1,x0,5 then add x2,x1,x1 (immediate acks) -> retire every 4 cycles; Debug_out(sel = 2) = 10.
- sw x2,8(x0) with dmem_ack delayed 3 cycles -> dmem_we = 2, addr = 8, wdata = 10 held for 4 cycles; retire at cycle 8.
- lw x3,8(x0) with dmem_rdata = 32'hDEADBEEF -> x3 = DEADBEEF after WB; addi x0,x0,7 -> x0 stays 0.
- beq taken to +16 from PC = 32'hFFFF_FFF0 -> PC wraps to 0; jal with RF_WD_SRC = 1 -> rd = old PC+4.
- Feature on, TIMEOUT_CYCLES = 16, imem_ack stuck at 0 -> bus_err = 1 after 16 cycles, req = 0, no retire; assert reset mid-MEM -> all outputs return to reset values immediately.
